// File: rtl/cla9_share_ctrl_pkg.sv
// Shared types and constants for the 9-bit CLA sharing controller.
package cla9_share_ctrl_pkg;

  localparam int SETTLE_DEFAULT = 1;
  localparam int OPW            = 9;
  localparam int SUMW           = 10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef struct packed {
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
    logic           mode;
  } cla_op_t;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/cla9_share_ctrl_if.sv
// Command/response channels between the two requesters and the shared adder controller.
interface cla9_share_ctrl_if;
  import cla9_share_ctrl_pkg::*;

  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [OPW-1:0]  req0_a;
  logic [OPW-1:0]  req0_b;
  logic            req0_mode;
  logic [OPW-1:0]  req1_a;
  logic [OPW-1:0]  req1_b;
  logic            req1_mode;
  logic [1:0]      rsp_valid;
  logic [1:0]      rsp_ready;
  logic [SUMW-1:0] rsp_sum;
  logic            rsp_cout;
  logic            rsp_ovfl;

  modport master (
    output req_valid, req0_a, req0_b, req0_mode, req1_a, req1_b, req1_mode, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_ovfl
  );

  modport slave (
    input  req_valid, req0_a, req0_b, req0_mode, req1_a, req1_b, req1_mode, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_ovfl
  );

endinterface

// File: rtl/cla9_share_ctrl_rr_arb2.sv
// Two-input round-robin arbiter; on a tie the requester that did not win last time is granted.
module cla9_share_ctrl_rr_arb2
  import cla9_share_ctrl_pkg::*;
#(
  parameter bit PRIO_INIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  logic last_grant;

  always_comb begin
    gnt_idx = req[1];
    if (req == 2'b11) gnt_idx = ~last_grant;
    gnt = (req == 2'b00) ? 2'b00 : onehot2(gnt_idx);
  end

  // Starting at ~PRIO_INIT makes PRIO_INIT the winner of the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  last_grant <= ~PRIO_INIT;
    else if (en) last_grant <= gnt_idx;
  end

endmodule

// File: rtl/cla9_share_ctrl.sv
// Shares one external 9-bit CLA add/sub unit between two requesters:
// arbitrate, register operands, wait the settle time, then hold the result until taken.
module cla9_share_ctrl
  import cla9_share_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = SETTLE_DEFAULT,
  parameter bit PRIO_INIT     = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  cla9_share_ctrl_if.slave ch,
  output logic [OPW-1:0]   add_a,
  output logic [OPW-1:0]   add_b,
  output logic             add_mode,
  input  logic [SUMW-1:0]  add_sum,
  input  logic             add_cout,
  input  logic             add_ovfl,
  output logic             busy
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  logic [1:0]       state;
  logic             owner;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       gnt;
  logic             gnt_idx;
  logic             accept;
  cla_op_t          win;

  assign accept       = (state == ST_IDLE) && (ch.req_valid != 2'b00);
  assign ch.req_ready = (state == ST_IDLE) ? gnt : 2'b00;
  assign busy         = (state != ST_IDLE);

  cla9_share_ctrl_rr_arb2 #(.PRIO_INIT(PRIO_INIT)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (ch.req_valid),
    .en      (accept),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    win = '{a: ch.req0_a, b: ch.req0_b, mode: ch.req0_mode};
    if (gnt_idx) win = '{a: ch.req1_a, b: ch.req1_b, mode: ch.req1_mode};
  end

  // Adder inputs stay frozen from accept until the response is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      owner        <= 1'b0;
      cnt          <= '0;
      add_a        <= '0;
      add_b        <= '0;
      add_mode     <= 1'b0;
      ch.rsp_valid <= 2'b00;
      ch.rsp_sum   <= '0;
      ch.rsp_cout  <= 1'b0;
      ch.rsp_ovfl  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            add_a    <= win.a;
            add_b    <= win.b;
            add_mode <= win.mode;
            owner    <= gnt_idx;
            cnt      <= CNT_W'(SETTLE_CYCLES - 1);
            state    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            ch.rsp_sum   <= add_sum;
            ch.rsp_cout  <= add_cout;
            ch.rsp_ovfl  <= add_ovfl;
            ch.rsp_valid <= onehot2(owner);
            state        <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (ch.rsp_ready[owner]) begin
            ch.rsp_valid <= 2'b00;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cla9_share_ctrl.sv
// Bench for cla9_share_ctrl: directed scenarios plus randomized traffic against a transaction-level model.
module tb_cla9_share_ctrl;
  import cla9_share_ctrl_pkg::*;

  localparam int S1 = 1;
  localparam int S3 = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cla9_share_ctrl_if ch();
  cla9_share_ctrl_if ch3();

  logic [8:0] add_a, add_b, add3_a, add3_b;
  logic       add_mode, add3_mode;
  logic [9:0] add_sum, add3_sum;
  logic       add_cout, add_ovfl, add3_cout, add3_ovfl;
  logic       busy, busy3;

  // Gate-style stand-in for the CLA_9bit that sits beside the controller.
  function automatic logic [11:0] cla_stub(input logic [8:0] a, input logic [8:0] b, input logic m);
    logic [8:0] bb;
    logic [9:0] s;
    bb = m ? ~b : b;
    s  = {1'b0, a} + {1'b0, bb} + {9'd0, m};
    return {(a[8] == bb[8]) && (s[8] != a[8]), s[9], s};
  endfunction

  assign {add_ovfl, add_cout, add_sum}    = cla_stub(add_a, add_b, add_mode);
  assign {add3_ovfl, add3_cout, add3_sum} = cla_stub(add3_a, add3_b, add3_mode);

  cla9_share_ctrl #(.SETTLE_CYCLES(S1), .PRIO_INIT(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .ch(ch),
    .add_a(add_a), .add_b(add_b), .add_mode(add_mode),
    .add_sum(add_sum), .add_cout(add_cout), .add_ovfl(add_ovfl), .busy(busy)
  );

  cla9_share_ctrl #(.SETTLE_CYCLES(S3), .PRIO_INIT(1'b0)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .ch(ch3),
    .add_a(add3_a), .add_b(add3_b), .add_mode(add3_mode),
    .add_sum(add3_sum), .add_cout(add3_cout), .add_ovfl(add3_ovfl), .busy(busy3)
  );

  int n_chk  = 0;
  int n_fail = 0;

  bit         pend [2];
  logic [8:0] opa  [2];
  logic [8:0] opb  [2];
  logic       opm  [2];
  bit         last_w;
  logic [11:0] last_rsp;

  // Plain-integer reference: sub is a + (512 - b); overflow is the signed result leaving [-256,255].
  function automatic logic [11:0] ref_model(input logic [8:0] a, input logic [8:0] b, input logic m);
    int ua, ub, sa, sb, raw, sres;
    logic [9:0] s;
    logic ov;
    ua   = int'(a);
    ub   = int'(b);
    sa   = a[8] ? ua - 512 : ua;
    sb   = b[8] ? ub - 512 : ub;
    raw  = m ? (ua + 512 - ub) : (ua + ub);
    sres = m ? (sa - sb) : (sa + sb);
    s    = raw[9:0];
    ov   = (sres > 255) || (sres < -256);
    return {ov, s[9], s};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_ops();
    ch.req0_a    = opa[0];
    ch.req0_b    = opb[0];
    ch.req0_mode = opm[0];
    ch.req1_a    = opa[1];
    ch.req1_b    = opb[1];
    ch.req1_mode = opm[1];
    ch.req_valid = {pend[1], pend[0]};
  endtask

  task automatic new_op(input int i);
    opa[i]  = 9'($urandom_range(0, 511));
    opb[i]  = 9'($urandom_range(0, 511));
    opm[i]  = 1'($urandom_range(0, 1));
    pend[i] = 1'b1;
  endtask

  // One complete transaction on the SETTLE=1 unit, entered and left just after a falling edge in IDLE.
  task automatic run_op(input int hold, input logic other_rdy, input string tag);
    int w, lat;
    logic [11:0] exp_rsp, held;
    drive_ops();
    #1;
    if (pend[0] && pend[1]) w = last_w ? 0 : 1;
    else                    w = pend[1] ? 1 : 0;
    chk({tag, "_req_ready"}, 32'(ch.req_ready), (w == 1) ? 32'h2 : 32'h1);
    exp_rsp = ref_model(opa[w], opb[w], opm[w]);
    last_w  = w[0];
    pend[w] = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      drive_ops();
      #1;
      lat++;
      if (lat == 1) begin
        chk({tag, "_exec_busy"}, 32'(busy), 32'h1);
        chk({tag, "_exec_ready"}, 32'(ch.req_ready), 32'h0);
        chk({tag, "_add_ops"}, 32'({add_a, add_b, add_mode}), 32'({opa[w], opb[w], opm[w]}));
      end
    end while (ch.rsp_valid == 2'b00 && lat < 20);
    chk({tag, "_latency"}, 32'(lat), 32'(S1 + 1));
    chk({tag, "_rsp_valid"}, 32'(ch.rsp_valid), (w == 1) ? 32'h2 : 32'h1);
    chk({tag, "_rsp"}, 32'({ch.rsp_ovfl, ch.rsp_cout, ch.rsp_sum}), 32'(exp_rsp));
    held = {ch.rsp_ovfl, ch.rsp_cout, ch.rsp_sum};
    last_rsp = held;
    ch.rsp_ready = (w == 1) ? {1'b0, other_rdy} : {other_rdy, 1'b0};
    repeat (hold) begin
      @(negedge clk);
      drive_ops();
    end
    #1;
    chk({tag, "_hold_rsp"}, 32'({ch.rsp_ovfl, ch.rsp_cout, ch.rsp_sum}), 32'(held));
    chk({tag, "_hold_valid"}, 32'(ch.rsp_valid), (w == 1) ? 32'h2 : 32'h1);
    chk({tag, "_hold_busy"}, 32'(busy), 32'h1);
    chk({tag, "_hold_ready"}, 32'(ch.req_ready), 32'h0);
    ch.rsp_ready[w] = 1'b1;
    @(negedge clk);
    drive_ops();
    #1;
    chk({tag, "_release_busy"}, 32'(busy), 32'h0);
    chk({tag, "_release_valid"}, 32'(ch.rsp_valid), 32'h0);
    ch.rsp_ready = 2'b00;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, cyc, nz;
    int         order_q [$];
    int         when_q  [$];
    logic [11:0] rsp_q  [$];

    rst_n = 1'b0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    opa[0] = '0; opb[0] = '0; opm[0] = 1'b0;
    opa[1] = '0; opb[1] = '0; opm[1] = 1'b0;
    last_w = 1'b1;
    last_rsp = '0;
    drive_ops();
    ch.rsp_ready = 2'b00;
    ch3.req_valid = 2'b00; ch3.rsp_ready = 2'b00;
    ch3.req0_a = '0; ch3.req0_b = '0; ch3.req0_mode = 1'b0;
    ch3.req1_a = '0; ch3.req1_b = '0; ch3.req1_mode = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rsp_valid", 32'(ch.rsp_valid), 32'h0);
    chk("rst_rsp", 32'({ch.rsp_ovfl, ch.rsp_cout, ch.rsp_sum}), 32'h0);
    chk("rst_add", 32'({add_a, add_b, add_mode}), 32'h0);
    chk("rst_req_ready", 32'(ch.req_ready), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: req0 0x0FF + 0x001
    opa[0] = 9'h0FF; opb[0] = 9'h001; opm[0] = 1'b0; pend[0] = 1'b1;
    run_op(0, 1'b0, "t1");
    chk("t1_sum", 32'(last_rsp[9:0]), 32'h100);
    chk("t1_ovfl", 32'(last_rsp[11]), 32'h1);

    // 2: req1 0x005 - 0x003
    opa[1] = 9'h005; opb[1] = 9'h003; opm[1] = 1'b1; pend[1] = 1'b1;
    run_op(0, 1'b1, "t2");
    chk("t2_sum_lo", 32'(last_rsp[8:0]), 32'h002);
    chk("t2_sum_hi", 32'(last_rsp[9]), 32'h1);
    chk("t2_ovfl", 32'(last_rsp[11]), 32'h0);

    // 4: response held off for 5 cycles while the other requester waits
    new_op(0);
    new_op(1);
    run_op(5, 1'b1, "t4");
    run_op(1, 1'b0, "t4_drain");

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < 2; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1) new_op(i);
      if (!pend[0] && !pend[1]) new_op(it % 2);
      run_op(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "rnd");
    end
    for (int k = 0; k < 2; k++)
      if (pend[0] || pend[1]) run_op(0, 1'b0, "drain");

    // 3: fairness under continuous requests from a fresh reset
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    last_w = 1'b1;
    @(negedge clk);
    opa[0] = 9'h0AA; opb[0] = 9'h055; opm[0] = 1'b0;
    opa[1] = 9'h010; opb[1] = 9'h020; opm[1] = 1'b1;
    pend[0] = 1'b1; pend[1] = 1'b1;
    drive_ops();
    ch.rsp_ready = 2'b11;
    cyc = 0;
    while (order_q.size() < 6 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (ch.rsp_valid != 2'b00) begin
        order_q.push_back(int'(ch.rsp_valid));
        when_q.push_back(cyc);
        rsp_q.push_back({ch.rsp_ovfl, ch.rsp_cout, ch.rsp_sum});
      end
    end
    ch.req_valid = 2'b00;
    pend[0] = 1'b0; pend[1] = 1'b0;
    chk("t3_nops", 32'(order_q.size()), 32'd6);
    for (int k = 0; k < order_q.size(); k++) begin
      chk($sformatf("t3_grant%0d", k), 32'(order_q[k]), (k % 2 == 1) ? 32'h2 : 32'h1);
      chk($sformatf("t3_rsp%0d", k), 32'(rsp_q[k]), 32'(ref_model(opa[k % 2], opb[k % 2], opm[k % 2])));
      if (k > 0) chk($sformatf("t3_period%0d", k), 32'(when_q[k] - when_q[k - 1]), 32'(S1 + 2));
    end
    @(negedge clk);
    chk("t3_idle", 32'(busy), 32'h0);
    ch.rsp_ready = 2'b00;
    last_w = 1'b1;

    // 5: reset while the operation is in EXEC
    opa[0] = 9'h1FF; opb[0] = 9'h1FF; opm[0] = 1'b1; pend[0] = 1'b1;
    drive_ops();
    @(negedge clk);
    #1;
    chk("t5_busy_exec", 32'(busy), 32'h1);
    pend[0] = 1'b0;
    drive_ops();
    rst_n = 1'b0;
    #1;
    chk("t5_busy", 32'(busy), 32'h0);
    chk("t5_rsp_valid", 32'(ch.rsp_valid), 32'h0);
    chk("t5_rsp", 32'({ch.rsp_ovfl, ch.rsp_cout, ch.rsp_sum}), 32'h0);
    chk("t5_add", 32'({add_a, add_b, add_mode}), 32'h0);
    chk("t5_req_ready", 32'(ch.req_ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    last_w = 1'b1;
    nz = 0;
    repeat (8) begin
      @(negedge clk);
      if (ch.rsp_valid != 2'b00 || busy) nz++;
    end
    chk("t5_no_rsp", 32'(nz), 32'h0);

    // 6: SETTLE_CYCLES=3 instance, 0x100 + 0x100
    ch3.req0_a = 9'h100; ch3.req0_b = 9'h100; ch3.req0_mode = 1'b0;
    ch3.req_valid = 2'b01;
    #1;
    chk("t6_req_ready", 32'(ch3.req_ready), 32'h1);
    lat = 0;
    do begin
      @(negedge clk);
      ch3.req_valid = 2'b00;
      lat++;
      if (lat == 2) chk("t6_add_a", 32'(add3_a), 32'h100);
    end while (ch3.rsp_valid == 2'b00 && lat < 20);
    chk("t6_latency", 32'(lat), 32'(S3 + 1));
    chk("t6_rsp_valid", 32'(ch3.rsp_valid), 32'h1);
    chk("t6_sum", 32'(ch3.rsp_sum), 32'h200);
    chk("t6_ovfl", 32'(ch3.rsp_ovfl), 32'h1);
    chk("t6_model", 32'({ch3.rsp_ovfl, ch3.rsp_cout, ch3.rsp_sum}), 32'(ref_model(9'h100, 9'h100, 1'b0)));
    ch3.rsp_ready = 2'b01;
    @(negedge clk);
    chk("t6_idle", 32'(busy3), 32'h0);
    ch3.rsp_ready = 2'b00;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
